eth_tx_buf_narrow8: RTL and testbench

- Transmit-side frame buffer for the Ethernet path; the counterpart of the RX widening buffer.
- The CPU writes a frame as 64-bit words with per-byte enables.
- On a start command, an internal reader FSM streams the frame to the MAC transmit path as bytes, using a valid/ready handshake.
- Single clock domain; 2 KiB of storage (256 x 64).

---
 rtl/eth_tx_buf_narrow8_if.sv | 29 ++
 rtl/eth_tx_buf_narrow8.sv | 168 ++++++++++++++++
 tb/tb_eth_tx_buf_narrow8.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_buf_narrow8_if.sv
// eth_tx_buf_narrow8_if: CPU buffer port plus start/length control and the byte-stream
// handshake of the TX frame buffer. master = CPU/MAC side, slave = buffer.
interface eth_tx_buf_narrow8_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 11
);
  logic [7:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [63:0]       cpu_wdata;
  logic [63:0]       cpu_rdata;
  logic              tx_start;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_busy;
  logic              tx_done;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, tx_start, tx_len, tx_ready,
    input  cpu_rdata, tx_busy, tx_done, tx_data, tx_valid, tx_last
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, tx_start, tx_len, tx_ready,
    output cpu_rdata, tx_busy, tx_done, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/eth_tx_buf_narrow8.sv
// eth_tx_buf_narrow8: 2^ADDR_W x 64 TX frame buffer streamed to the MAC one byte per cycle.
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME bytes.
module eth_tx_buf_narrow8 #(
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 11,
  parameter int MIN_FRAME = 60
) (
  input logic                 clk,
  input logic                 rst,
  eth_tx_buf_narrow8_if.slave bus
);
  localparam int WORDS = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 4;
  localparam int CMP_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;
  localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(WORDS * 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  logic [63:0]       mem_q [WORDS];
  logic [63:0]       cpu_rdata_q;
  logic [63:0]       nxt_word_q;
  logic [63:0]       cur_word_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_en_q;
  state_t            state_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              last_q;
`ifdef ETH_TX_PAD_EN
  logic [CNT_W-1:0]  orig_len_q;
`endif

  logic [CMP_W-1:0]  len_ext;
  logic [CNT_W-1:0]  len_clamp;
  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] word_idx;
  logic [63:0]       cur_load_d;
  logic [63:0]       cur_step_d;
  logic              hs;

  always_comb begin
    len_ext   = CMP_W'(bus.tx_len);
    len_clamp = (len_ext > MAX_LEN) ? CNT_W'(MAX_LEN) : CNT_W'(bus.tx_len);
    len_eff   = len_clamp;
`ifdef ETH_TX_PAD_EN
    if (len_clamp < CNT_W'(MIN_FRAME)) len_eff = CNT_W'(MIN_FRAME);
`endif
    hs         = valid_q & bus.tx_ready;
    cnt_d      = cnt_q + CNT_W'(1);
    word_idx   = cnt_q[ADDR_W+2:3];
    cur_load_d = nxt_word_q;
    // Lane 7 going out means the prefetched word becomes the working word.
    cur_step_d = (cnt_q[2:0] == 3'd7) ? nxt_word_q : {8'h00, cur_word_q[63:8]};
`ifdef ETH_TX_PAD_EN
    if (orig_len_q == '0) cur_load_d[7:0] = 8'h00;
    if (cnt_d >= orig_len_q) cur_step_d[7:0] = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_we[i]) mem_q[bus.cpu_addr][8*i +: 8] <= bus.cpu_wdata[8*i +: 8];
    end
  end

  // Both read ports sample the array before a same-edge write lands (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      nxt_word_q  <= '0;
    end else begin
      cpu_rdata_q <= mem_q[bus.cpu_addr];
      if (rd_en_q) nxt_word_q <= mem_q[rd_addr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      cur_word_q <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
`ifdef ETH_TX_PAD_EN
      orig_len_q <= '0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.tx_start) begin
            len_q     <= len_eff;
`ifdef ETH_TX_PAD_EN
            orig_len_q <= len_clamp;
`endif
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_addr_q <= ADDR_W'(1);
          rd_en_q   <= 1'b1;
          if (len_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cur_word_q <= cur_load_d;
          valid_q    <= 1'b1;
          last_q     <= (len_q == CNT_W'(1));
          state_q    <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            cnt_q <= cnt_d;
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_word_q <= cur_step_d;
              last_q     <= (cnt_d == len_q - CNT_W'(1));
              if (cnt_q[2:0] == 3'd7) begin
                rd_addr_q <= word_idx + ADDR_W'(2);
                rd_en_q   <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.tx_busy   = busy_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_data   = cur_word_q[7:0];
  assign bus.tx_valid  = valid_q;
  assign bus.tx_last   = last_q;
endmodule

// File: tb/tb_eth_tx_buf_narrow8.sv
// Scoreboard bench for eth_tx_buf_narrow8: stimulus queues expected bytes, a negedge monitor checks them.
// Built with LEN_W=12 so over-long lengths (3000) can reach the clamp.
module tb_eth_tx_buf_narrow8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_buf_narrow8_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_if ();

  eth_tx_buf_narrow8 #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MIN_FRAME(60)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
  int ready_mode = 0;
  int ph = 0;
  int rd0, ra0, pad_n;
  logic [63:0] mdl [256];
  logic [63:0] wtmp;
  logic [8:0]  exp_q [$];
  logic [8:0]  e;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;

  always @(posedge clk) cyc <= cyc + 1;

  // ready pattern 1,0,0,1 when ready_mode != 0
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) bus_if.tx_ready = 1'b1;
    else begin
      bus_if.tx_ready = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mbyte(input int k);
    logic [63:0] w;
    w = mdl[k / 8];
    return w[8*(k % 8) +: 8];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend)
        chk("hold_stable", 64'({bus_if.tx_valid, bus_if.tx_last, bus_if.tx_data}),
            64'({1'b1, hold_last, hold_data}));
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h last=%0b, expected no byte (cycle %0d)",
                   bus_if.tx_data, bus_if.tx_last, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", 64'({bus_if.tx_last, bus_if.tx_data}), 64'(e));
        end
        acc_cnt++;
        if (bus_if.tx_last) last_cyc = cyc;
      end
      if (bus_if.tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_pend = bus_if.tx_valid && !bus_if.tx_ready;
      hold_data = bus_if.tx_data;
      hold_last = bus_if.tx_last;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic cpu_write(input int a, input logic [7:0] we, input logic [63:0] d);
    @(posedge clk); #1;
    bus_if.cpu_addr  = a[7:0];
    bus_if.cpu_we    = we;
    bus_if.cpu_wdata = d;
    for (int i = 0; i < 8; i++) if (we[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    @(posedge clk); #1;
    bus_if.cpu_we = '0;
  endtask

  task automatic cpu_read_chk(input string nm, input int a, input logic [63:0] exp);
    @(posedge clk); #1;
    bus_if.cpu_addr = a[7:0];
    bus_if.cpu_we   = '0;
    @(posedge clk); #1;
    chk(nm, bus_if.cpu_rdata, exp);
  endtask

  task automatic run_frame(input string nm, input int len, input int n_exp, input int pad_from,
                           input bit mid_start);
    int s, d0, a0;
    for (int k = 0; k < n_exp; k++)
      exp_q.push_back({k == n_exp - 1, (k >= pad_from) ? 8'h00 : mbyte(k)});
    d0 = done_cnt;
    a0 = acc_cnt;
    @(posedge clk); #1;
    bus_if.tx_len   = len[LEN_W-1:0];
    bus_if.tx_start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    bus_if.tx_start = 1'b0;
    chk({nm, "_busy"}, 64'(bus_if.tx_busy), 64'd1);
    if (n_exp > 0) begin
      @(posedge clk); #1;
      chk({nm, "_valid_early"}, 64'(bus_if.tx_valid), 64'd0);
      @(posedge clk); #1;
      chk({nm, "_valid_lat3"}, 64'(bus_if.tx_valid), 64'd1);
    end
    if (mid_start) begin
      repeat (4) @(posedge clk);
      #1;
      bus_if.tx_len   = 4;
      bus_if.tx_start = 1'b1;
      @(posedge clk); #1;
      bus_if.tx_start = 1'b0;
    end
    for (int t = 0; t < 5000 && done_cnt == d0; t++) begin
      @(posedge clk); #1;
    end
    chk_int({nm, "_done_cnt"}, done_cnt - d0, 1);
    if (n_exp == 0) begin
      chk_int({nm, "_done_lat"}, done_cyc, s + 2);
      chk_int({nm, "_bytes"}, acc_cnt - a0, 0);
    end else begin
      chk_int({nm, "_done_lat"}, done_cyc, last_cyc + 1);
      chk_int({nm, "_bytes"}, acc_cnt - a0, n_exp);
    end
    @(posedge clk); #1;
    chk({nm, "_busy_end"}, 64'(bus_if.tx_busy), 64'd0);
    chk_int({nm, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.cpu_we    = '0;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = '0;
    bus_if.tx_start  = 1'b0;
    bus_if.tx_len    = '0;
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus_if.tx_valid), 64'd0);
    chk("rst_last", 64'(bus_if.tx_last), 64'd0);
    chk("rst_data", 64'(bus_if.tx_data), 64'd0);
    chk("rst_busy", 64'(bus_if.tx_busy), 64'd0);
    chk("rst_done", 64'(bus_if.tx_done), 64'd0);
    chk("rst_rdata", bus_if.cpu_rdata, 64'd0);
    rst = 1'b0;

    cpu_write(0, 8'hFF, 64'h0706050403020100);
    cpu_write(1, 8'hFF, 64'h0F0E0D0C0B0A0908);
    cpu_read_chk("rd_word1", 1, 64'h0F0E0D0C0B0A0908);
    cpu_write(10, 8'hFF, 64'h1122334455667788);
    cpu_write(10, 8'h0F, 64'hAAAAAAAABBBBBBBB);
    cpu_read_chk("rd_byte_en", 10, 64'h11223344BBBBBBBB);

    ready_mode = 0;
    run_frame("len16", 16, 16, 16, 1'b0);
    ready_mode = 1;
    run_frame("len16_bp", 16, 16, 16, 1'b0);
    ready_mode = 0;
    run_frame("len13", 13, 13, 13, 1'b0);
    run_frame("midstart", 16, 16, 16, 1'b1);
`ifdef ETH_TX_PAD_EN
    run_frame("len0", 0, 60, 0, 1'b0);
`else
    run_frame("len0", 0, 0, 0, 1'b0);
`endif

    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < 8; i++) wtmp[8*i +: 8] = 8'((8*w + i) + ((8*w + i) >> 8));
      cpu_write(w, 8'hFF, wtmp);
    end
    run_frame("clamp", 3000, 2048, 2048, 1'b0);

    for (int k = 0; k < 2048; k++) exp_q.push_back({k == 2047, mbyte(k)});
    rd0 = done_cnt;
    ra0 = acc_cnt;
    @(posedge clk); #1;
    bus_if.tx_len   = 3000;
    bus_if.tx_start = 1'b1;
    @(posedge clk); #1;
    bus_if.tx_start = 1'b0;
    for (int t = 0; t < 500 && (acc_cnt - ra0) < 100; t++) begin
      @(posedge clk); #1;
    end
    chk_int("rst_at_byte", acc_cnt - ra0, 100);
    chk("pre_rst_valid", 64'(bus_if.tx_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus_if.tx_valid), 64'd0);
    chk("midrst_last", 64'(bus_if.tx_last), 64'd0);
    chk("midrst_data", 64'(bus_if.tx_data), 64'd0);
    chk("midrst_busy", 64'(bus_if.tx_busy), 64'd0);
    chk("midrst_rdata", bus_if.cpu_rdata, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_int("midrst_no_done", done_cnt - rd0, 0);
    chk("midrst_idle", 64'(bus_if.tx_busy), 64'd0);
    run_frame("after_rst", 16, 16, 16, 1'b0);

`ifdef ETH_TX_PAD_EN
    pad_n = 60;
`else
    pad_n = 10;
`endif
    run_frame("pad", 10, pad_n, 10, 1'b0);
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
